// File: rtl/dot_product_engine.sv
// LANES-wide pipelined fixed-point dot product with a start/done handshake.
// Define DP_SATURATE_EN to clamp out-of-range results; otherwise the result wraps.
module dot_product_engine #(
  parameter int unsigned PIXEL_N     = 10,
  parameter int unsigned PIXEL_SIZE  = 10,
  parameter int unsigned WEIGHT_SIZE = 19,
  parameter int unsigned VAL_SIZE    = 26,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned LANES       = 2,
  parameter int unsigned MUL_LAT     = 3
) (
  input  logic                              clk,
  input  logic                              GlobalReset_n,
  input  logic                              start,
  input  logic [PIXEL_N*PIXEL_SIZE-1:0]     Pixels,
  input  logic [PIXEL_N*WEIGHT_SIZE-1:0]    Weights,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [VAL_SIZE-1:0]        value,
  output logic                              ovf
);

  localparam int unsigned B      = (PIXEL_N + LANES - 1) / LANES;
  localparam int unsigned ProdW  = PIXEL_SIZE + WEIGHT_SIZE + 1;
  localparam int unsigned AccW   = ProdW + $clog2(PIXEL_N);
  localparam int unsigned SumW   = (AccW > VAL_SIZE) ? AccW : VAL_SIZE + 1;
  localparam int unsigned CntMax = (B > MUL_LAT) ? B : MUL_LAT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StMac, StDrain, StReduce, StDone} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [PIXEL_N*PIXEL_SIZE-1:0]  pix_q;
  logic [PIXEL_N*WEIGHT_SIZE-1:0] wgt_q;
  logic signed [AccW-1:0]         acc_q  [LANES];
  logic signed [ProdW-1:0]        prod_q [MUL_LAT][LANES];
  logic [MUL_LAT-1:0]             vld_q;
  logic signed [VAL_SIZE-1:0]     value_q, val_d;
  logic                           ovf_q, ovf_d;

  logic [PIXEL_SIZE-1:0]          pix_e  [LANES];
  logic signed [WEIGHT_SIZE-1:0]  wgt_e  [LANES];
  logic signed [ProdW-1:0]        prod_d [LANES];
  logic signed [SumW-1:0]         sum_w, shifted;
  logic [SumW-VAL_SIZE:0]         hi_bits;
  logic                           issue, accept;
  int unsigned                    beat_base;

  assign accept    = (state_q == StIdle) && start;
  assign issue     = (state_q == StMac);
  assign beat_base = int'(cnt_q) * LANES;

  // State register
  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) state_q <= StIdle;
    else                state_q <= state_d;
  end

  // Next-state and beat/drain counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) state_d = StMac;
      end
      StMac: begin
        if (cnt_q == CntW'(B - 1)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        // Last beat leaves the multiplier pipeline and is accumulated on this edge.
        if (cnt_q == CntW'(MUL_LAT - 1)) begin
          state_d = StReduce;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReduce: state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
    value     = value_q;
    ovf       = ovf_q;
  end

  // Lane operand select; elements past PIXEL_N read as zero.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      pix_e[l] = '0;
      wgt_e[l] = '0;
      if (beat_base + l < PIXEL_N) begin
        pix_e[l] = pix_q[(beat_base + l) * PIXEL_SIZE +: PIXEL_SIZE];
        wgt_e[l] = $signed(wgt_q[(beat_base + l) * WEIGHT_SIZE +: WEIGHT_SIZE]);
      end
      prod_d[l] = ProdW'($signed({1'b0, pix_e[l]})) * ProdW'(wgt_e[l]);
    end
  end

  // Lane reduction, scaling and range check
  always_comb begin
    sum_w = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      sum_w = sum_w + SumW'(acc_q[l]);
    end
    shifted = sum_w >>> FRAC_BITS;
    hi_bits = shifted[SumW-1:VAL_SIZE-1];
    ovf_d   = !((&hi_bits) || !(|hi_bits));
`ifdef DP_SATURATE_EN
    if (ovf_d) begin
      val_d = shifted[SumW-1] ? {1'b1, {(VAL_SIZE-1){1'b0}}} : {1'b0, {(VAL_SIZE-1){1'b1}}};
    end else begin
      val_d = shifted[VAL_SIZE-1:0];
    end
`else
    val_d = shifted[VAL_SIZE-1:0];
`endif
  end

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      cnt_q   <= '0;
      pix_q   <= '0;
      wgt_q   <= '0;
      vld_q   <= '0;
      value_q <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
        for (int unsigned s = 0; s < MUL_LAT; s++) prod_q[s][l] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      vld_q[0] <= issue;
      for (int unsigned s = 1; s < MUL_LAT; s++) vld_q[s] <= vld_q[s-1];
      for (int unsigned l = 0; l < LANES; l++) begin
        prod_q[0][l] <= prod_d[l];
        for (int unsigned s = 1; s < MUL_LAT; s++) prod_q[s][l] <= prod_q[s-1][l];
      end
      if (accept) begin
        pix_q <= Pixels;
        wgt_q <= Weights;
        for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= '0;
      end else if (vld_q[MUL_LAT-1]) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          acc_q[l] <= acc_q[l] + AccW'(prod_q[MUL_LAT-1][l]);
        end
      end
      if (state_q == StReduce) begin
        value_q <= val_d;
        ovf_q   <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine across several lane/latency/width configurations.
// Honours DP_SATURATE_EN for the narrow-result expectations.
module tb_dot_product_engine;

  localparam int NDUT = 5;

  typedef struct {
    logic [99:0]  pix;
    logic [189:0] wgt;
    longint       e26;
    bit           o26;
    longint       e20s;
    longint       e20w;
    bit           o20;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               out_ready;
  logic [99:0]        Pixels;
  logic [189:0]       Weights;
  logic               bz [NDUT];
  logic               ov [NDUT];
  logic               of [NDUT];
  logic signed [25:0] v26 [4];
  logic signed [19:0] v20;

  int nchk  = 0;
  int nfail = 0;
  int lat_exp [NDUT] = '{9, 9, 12, 6, 9};
  vec_t vt [7];

  always #5 clk = ~clk;

  dot_product_engine u_d0 (
    .clk(clk), .GlobalReset_n(rst_n), .start(start), .Pixels(Pixels), .Weights(Weights),
    .busy(bz[0]), .out_valid(ov[0]), .out_ready(out_ready), .value(v26[0]), .ovf(of[0]));

  dot_product_engine #(.LANES(3), .MUL_LAT(4)) u_d1 (
    .clk(clk), .GlobalReset_n(rst_n), .start(start), .Pixels(Pixels), .Weights(Weights),
    .busy(bz[1]), .out_valid(ov[1]), .out_ready(out_ready), .value(v26[1]), .ovf(of[1]));

  dot_product_engine #(.LANES(1), .MUL_LAT(1)) u_d2 (
    .clk(clk), .GlobalReset_n(rst_n), .start(start), .Pixels(Pixels), .Weights(Weights),
    .busy(bz[2]), .out_valid(ov[2]), .out_ready(out_ready), .value(v26[2]), .ovf(of[2]));

  dot_product_engine #(.LANES(10), .MUL_LAT(4)) u_d3 (
    .clk(clk), .GlobalReset_n(rst_n), .start(start), .Pixels(Pixels), .Weights(Weights),
    .busy(bz[3]), .out_valid(ov[3]), .out_ready(out_ready), .value(v26[3]), .ovf(of[3]));

  dot_product_engine #(.VAL_SIZE(20)) u_d4 (
    .clk(clk), .GlobalReset_n(rst_n), .start(start), .Pixels(Pixels), .Weights(Weights),
    .busy(bz[4]), .out_valid(ov[4]), .out_ready(out_ready), .value(v20), .ovf(of[4]));

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint dut_val(input int d);
    if (d < 4) return longint'(v26[d]);
    return longint'(v20);
  endfunction

  function automatic logic [99:0] pix_all(input int v);
    logic [99:0] r;
    for (int i = 0; i < 10; i++) r[i*10 +: 10] = 10'(v);
    return r;
  endfunction

  function automatic logic [189:0] wgt_all(input int v);
    logic [189:0] r;
    for (int i = 0; i < 10; i++) r[i*19 +: 19] = 19'(v);
    return r;
  endfunction

  // Reference: exact 64-bit sum, floor shift, then wrap or clamp to vs bits.
  task automatic model(input logic [99:0] p, input logic [189:0] w, input int vs,
                       output longint v, output bit o);
    longint sum, sh, lim;
    sum = 0;
    for (int i = 0; i < 10; i++) begin
      sum += longint'($signed(w[i*19 +: 19])) * longint'(p[i*10 +: 10]);
    end
    sh  = sum >>> 8;
    lim = longint'(1) <<< (vs - 1);
    o   = (sh >= lim) || (sh < -lim);
`ifdef DP_SATURATE_EN
    v = !o ? sh : (sh < 0 ? -lim : lim - 1);
`else
    v = (sh <<< (64 - vs)) >>> (64 - vs);
`endif
  endtask

  task automatic start_job(input logic [99:0] p, input logic [189:0] w, input longint e26,
                           input bit o26, input longint e20, input bit o20, input string tag);
    int lat [NDUT];
    bit seen [NDUT];
    int nseen;
    @(negedge clk);
    Pixels  = p;
    Weights = w;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    Pixels  = ~p;
    Weights = ~w;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("%s_busy%0d", tag, d), longint'(bz[d]), 1);
      lat[d]  = 0;
      seen[d] = 1'b0;
    end
    nseen = 0;
    for (int n = 1; n <= 40 && nseen < NDUT; n++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
        if (!seen[d] && ov[d]) begin
          seen[d] = 1'b1;
          lat[d]  = n;
          nseen++;
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("%s_lat%0d", tag, d), lat[d], lat_exp[d]);
      chk($sformatf("%s_val%0d", tag, d), dut_val(d), (d < 4) ? e26 : e20);
      chk($sformatf("%s_ovf%0d", tag, d), longint'(of[d]), (d < 4) ? o26 : o20);
    end
  endtask

  task automatic release_job(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("%s_rel%0d", tag, d), longint'({bz[d], ov[d]}), 0);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic longint e20_of(input vec_t v);
`ifdef DP_SATURATE_EN
    return v.e20s;
`else
    return v.e20w;
`endif
  endfunction

  initial begin
    logic [99:0]  rp;
    logic [189:0] rw;
    longint       m26, m20, held;
    bit           mo26, mo20;
    int           bad;

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; Pixels = '0; Weights = '0;

    vt[0] = '{pix: '0, wgt: wgt_all(256), e26: 55, o26: 0, e20s: 55, e20w: 55, o20: 0};
    for (int i = 0; i < 10; i++) vt[0].pix[i*10 +: 10] = 10'(i + 1);
    vt[1] = '{pix: pix_all(1023), wgt: wgt_all(-256), e26: -10230, o26: 0,
              e20s: -10230, e20w: -10230, o20: 0};
    vt[2] = '{pix: pix_all(1023), wgt: wgt_all(262143), e26: 10475480, o26: 0,
              e20s: 524287, e20w: -10280, o20: 1};
    vt[3] = '{pix: pix_all(1023), wgt: wgt_all(-262144), e26: -10475520, o26: 0,
              e20s: -524288, e20w: 10240, o20: 1};
    vt[4] = '{pix: '0, wgt: '0, e26: -1, o26: 0, e20s: -1, e20w: -1, o20: 0};
    vt[4].pix[9:0]  = 10'd1;
    vt[4].wgt[18:0] = 19'h7ffff;
    vt[5] = '{pix: '0, wgt: '0, e26: 5, o26: 0, e20s: 5, e20w: 5, o20: 0};
    vt[5].pix[99:90]   = 10'd5;
    vt[5].wgt[189:171] = 19'd300;
    vt[6] = '{pix: '0, wgt: '0, e26: -500, o26: 0, e20s: -500, e20w: -500, o20: 0};
    for (int i = 0; i < 10; i++) begin
      vt[6].pix[i*10 +: 10] = 10'(i * 50);
      vt[6].wgt[i*19 +: 19] = (i % 2 == 0) ? 19'd512 : 19'h7fe00;
    end

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("reset_ctl%0d", d), longint'({bz[d], ov[d], of[d]}), 0);
      chk($sformatf("reset_val%0d", d), dut_val(d), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      start_job(vt[k].pix, vt[k].wgt, vt[k].e26, vt[k].o26, e20_of(vt[k]), vt[k].o20,
                $sformatf("vec%0d", k));
      release_job($sformatf("vec%0d", k));
    end

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 10; i++) begin
        rp[i*10 +: 10] = 10'($urandom_range(0, 1023));
        rw[i*19 +: 19] = 19'($urandom);
      end
      model(rp, rw, 26, m26, mo26);
      model(rp, rw, 20, m20, mo20);
      start_job(rp, rw, m26, mo26, m20, mo20, $sformatf("rnd%0d", k));
      release_job($sformatf("rnd%0d", k));
    end

    // DONE hold: consumer stalls, start pulses must not disturb the held result.
    start_job(vt[0].pix, vt[0].wgt, vt[0].e26, vt[0].o26, e20_of(vt[0]), vt[0].o20, "hold");
    held = dut_val(0);
    bad  = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      start  = 1'b1;
      Pixels = pix_all(n + 7);
      @(posedge clk);
      #1;
      if (!ov[0] || !bz[0] || dut_val(0) != held) bad++;
    end
    chk("hold_stable", bad, 0);
    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_exit_busy", longint'(bz[0]), 0);
    chk("hold_exit_valid", longint'(ov[0]), 0);
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    start_job(vt[1].pix, vt[1].wgt, vt[1].e26, vt[1].o26, e20_of(vt[1]), vt[1].o20, "after");
    release_job("after");

    // Abort mid-MAC with reset, then confirm a clean job follows.
    @(negedge clk);
    Pixels  = vt[2].pix;
    Weights = vt[2].wgt;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("abort_ctl%0d", d), longint'({bz[d], ov[d], of[d]}), 0);
      chk($sformatf("abort_val%0d", d), dut_val(d), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_job(vt[3].pix, vt[3].wgt, vt[3].e26, vt[3].o26, e20_of(vt[3]), vt[3].o20, "fresh");
    release_job("fresh");

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
